// File: rtl/adma_cm_xfer_stat_pkg.sv
// Shared types, defaults and helpers for the ADMA transfer-status tracker.
// Optional watchdog: ADMA_XFER_STAT_TIMEOUT_EN.
package adma_cm_xfer_stat_pkg;

  localparam int DEF_CHN_NUM    = 4;
  localparam int DEF_DESC_DEPTH = 4;
  localparam int DEF_XFER_CNT_W = 8;
  localparam int DEF_IRQ_COAL_W = 4;
  localparam int DEF_TIMEOUT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } xfer_stat_e;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/adma_cm_xfer_stat_chn.sv
// One DMA channel: descriptor status FSMs, completion counters, coalesced irq.
// Watchdog built only with ADMA_XFER_STAT_TIMEOUT_EN.
module adma_cm_xfer_stat_chn
  import adma_cm_xfer_stat_pkg::*;
#(
  parameter int DESC       = DEF_DESC_DEPTH,
  parameter int XFER_CNT_W = DEF_XFER_CNT_W,
  parameter int IRQ_COAL_W = DEF_IRQ_COAL_W,
  parameter int TIMEOUT_W  = DEF_TIMEOUT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DESC-1:0]       start_i,
  input  logic [DESC-1:0]       done_set_i,
  input  logic [DESC-1:0]       err_set_i,
  input  logic [DESC-1:0]       clear_i,
  input  logic                  cyclic_i,
  input  logic                  irq_en_i,
  input  logic [IRQ_COAL_W-1:0] thresh_i,
  input  logic [TIMEOUT_W-1:0]  timeout_i,
  input  logic                  irq_ack_i,
  output logic [DESC-1:0]       busy_o,
  output logic [DESC-1:0]       done_o,
  output logic [DESC-1:0]       err_o,
  output logic [XFER_CNT_W-1:0] cnt_o,
  output logic                  irq_o
);

  localparam int CW = IRQ_COAL_W + 6;

  xfer_stat_e st_q [DESC];
  xfer_stat_e st_d [DESC];

  logic [DESC-1:0]       enter_done;
  logic [DESC-1:0]       err_nxt;
  logic [DESC-1:0]       wd_kill;
  logic [5:0]            c;
  logic [XFER_CNT_W-1:0] cnt_q, cnt_d;
  logic [IRQ_COAL_W-1:0] coal_q, coal_d;
  logic [IRQ_COAL_W-1:0] thr;
  logic [CW-1:0]         coal_sum;
  logic                  irq_q, irq_d;

  always_comb begin
    busy_o = '0;
    done_o = '0;
    err_o  = '0;
    for (int i = 0; i < DESC; i++) begin
      busy_o[i] = (st_q[i] == BUSY);
      done_o[i] = (st_q[i] == DONE);
      err_o[i]  = (st_q[i] == ERR);
    end
  end

`ifdef ADMA_XFER_STAT_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 wd_fire;
  logic                 wd_evt;

  assign wd_evt  = |(start_i | done_set_i | err_set_i);
  assign wd_fire = (timeout_i != '0) && (|busy_o)
                && (wd_q == timeout_i);
  assign wd_kill = {DESC{wd_fire}};

  always_comb begin
    wd_d = wd_q + 1'b1;
    if (!(|busy_o) || wd_evt || wd_fire) begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
  assign wd_kill = '0;
`endif

  always_comb begin
    enter_done = '0;
    err_nxt    = '0;
    for (int i = 0; i < DESC; i++) begin
      st_d[i] = st_q[i];
      unique case (st_q[i])
        IDLE: if (start_i[i]) st_d[i] = BUSY;
        BUSY: begin
          if (err_set_i[i]) begin
            st_d[i] = ERR;
          end else if (done_set_i[i]) begin
            st_d[i]       = DONE;
            enter_done[i] = 1'b1;
          end else if (wd_kill[i]) begin
            st_d[i] = ERR;
          end
        end
        // start wins over clear/cyclic so back-to-back descriptors chain
        DONE: begin
          if (start_i[i])                st_d[i] = BUSY;
          else if (clear_i[i] || cyclic_i) st_d[i] = IDLE;
        end
        ERR: if (clear_i[i]) st_d[i] = IDLE;
        default: st_d[i] = IDLE;
      endcase
      err_nxt[i] = (st_d[i] == ERR);
    end
  end

  assign c        = popcount(32'(enter_done));
  assign cnt_d    = cnt_q + XFER_CNT_W'(c);
  assign coal_sum = (irq_ack_i ? '0 : CW'(coal_q)) + CW'(c);
  assign coal_d   = (coal_sum > CW'({IRQ_COAL_W{1'b1}}))
                  ? '1 : coal_sum[IRQ_COAL_W-1:0];
  assign thr      = (thresh_i == '0) ? IRQ_COAL_W'(1) : thresh_i;
  assign irq_d    = irq_en_i & ((coal_d >= thr) | (|err_nxt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DESC; i++) st_q[i] <= IDLE;
      cnt_q  <= '0;
      coal_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DESC; i++) st_q[i] <= st_d[i];
      cnt_q  <= cnt_d;
      coal_q <= coal_d;
      irq_q  <= irq_d;
    end
  end

  assign cnt_o = cnt_q;
  assign irq_o = irq_q;

endmodule

// File: rtl/adma_cm_xfer_stat_ctrl.sv
// Multi-channel transfer-status tracker top; slices buses per channel.
// Optional watchdog: ADMA_XFER_STAT_TIMEOUT_EN.
module adma_cm_xfer_stat_ctrl
  import adma_cm_xfer_stat_pkg::*;
#(
  parameter int DMA_CHN_NUM    = DEF_CHN_NUM,
  parameter int DMA_DESC_DEPTH = DEF_DESC_DEPTH,
  parameter int XFER_CNT_W     = DEF_XFER_CNT_W,
  parameter int IRQ_COAL_W     = DEF_IRQ_COAL_W,
  parameter int TIMEOUT_W      = DEF_TIMEOUT_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DMA_CHN_NUM*DMA_DESC_DEPTH-1:0] xfer_start,
  input  logic [DMA_CHN_NUM*DMA_DESC_DEPTH-1:0] xfer_done_set,
  input  logic [DMA_CHN_NUM*DMA_DESC_DEPTH-1:0] xfer_err_set,
  input  logic [DMA_CHN_NUM*DMA_DESC_DEPTH-1:0] xfer_done_clear,
  input  logic [DMA_CHN_NUM-1:0]              chn_xfer_cyclic,
  input  logic [DMA_CHN_NUM-1:0]              chn_irq_en,
  input  logic [DMA_CHN_NUM*IRQ_COAL_W-1:0]   chn_irq_thresh,
  input  logic [DMA_CHN_NUM*TIMEOUT_W-1:0]    chn_timeout,
  input  logic [DMA_CHN_NUM-1:0]              irq_ack,
  output logic [DMA_CHN_NUM*DMA_DESC_DEPTH-1:0] xfer_busy,
  output logic [DMA_CHN_NUM*DMA_DESC_DEPTH-1:0] xfer_done,
  output logic [DMA_CHN_NUM*DMA_DESC_DEPTH-1:0] xfer_err,
  output logic [DMA_CHN_NUM*XFER_CNT_W-1:0]   chn_xfer_cnt,
  output logic [DMA_CHN_NUM-1:0]              chn_irq
);

  localparam int D = DMA_DESC_DEPTH;

  for (genvar g = 0; g < DMA_CHN_NUM; g++) begin : g_chn
    adma_cm_xfer_stat_chn #(
      .DESC       (D),
      .XFER_CNT_W (XFER_CNT_W),
      .IRQ_COAL_W (IRQ_COAL_W),
      .TIMEOUT_W  (TIMEOUT_W)
    ) u_chn (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (xfer_start[g*D +: D]),
      .done_set_i (xfer_done_set[g*D +: D]),
      .err_set_i  (xfer_err_set[g*D +: D]),
      .clear_i    (xfer_done_clear[g*D +: D]),
      .cyclic_i   (chn_xfer_cyclic[g]),
      .irq_en_i   (chn_irq_en[g]),
      .thresh_i   (chn_irq_thresh[g*IRQ_COAL_W +: IRQ_COAL_W]),
      .timeout_i  (chn_timeout[g*TIMEOUT_W +: TIMEOUT_W]),
      .irq_ack_i  (irq_ack[g]),
      .busy_o     (xfer_busy[g*D +: D]),
      .done_o     (xfer_done[g*D +: D]),
      .err_o      (xfer_err[g*D +: D]),
      .cnt_o      (chn_xfer_cnt[g*XFER_CNT_W +: XFER_CNT_W]),
      .irq_o      (chn_irq[g])
    );
  end

endmodule

// File: tb/tb_adma_cm_xfer_stat_ctrl.sv
// Directed + randomized bench for adma_cm_xfer_stat_ctrl with a status/counter model.
// Watchdog steps compiled in with ADMA_XFER_STAT_TIMEOUT_EN.
module tb_adma_cm_xfer_stat_ctrl;

  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  logic        clk;
  logic        rst_n;
  logic [15:0] start, dset, eset, clr;
  logic [3:0]  cyc, en, ack;
  logic [15:0] thresh;
  logic [63:0] tmo;
  logic [15:0] xfer_busy, xfer_done, xfer_err;
  logic [31:0] chn_xfer_cnt;
  logic [3:0]  chn_irq;

  int n_chk = 0;
  int n_err = 0;

  int mst  [16];
  int mcnt [4];
  int mcoal[4];
  bit mirq [4];

  adma_cm_xfer_stat_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .xfer_start      (start),
    .xfer_done_set   (dset),
    .xfer_err_set    (eset),
    .xfer_done_clear (clr),
    .chn_xfer_cyclic (cyc),
    .chn_irq_en      (en),
    .chn_irq_thresh  (thresh),
    .chn_timeout     (tmo),
    .irq_ack         (ack),
    .xfer_busy       (xfer_busy),
    .xfer_done       (xfer_done),
    .xfer_err        (xfer_err),
    .chn_xfer_cnt    (chn_xfer_cnt),
    .chn_irq         (chn_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mst[i] = M_IDLE;
    for (int ch = 0; ch < 4; ch++) begin
      mcnt[ch]  = 0;
      mcoal[ch] = 0;
      mirq[ch]  = 1'b0;
    end
  endfunction

  function automatic void model_step();
    for (int ch = 0; ch < 4; ch++) begin
      int c;
      int th;
      int b;
      bit anyerr;
      c = 0;
      anyerr = 1'b0;
      for (int d = 0; d < 4; d++) begin
        b = ch * 4 + d;
        case (mst[b])
          M_IDLE: if (start[b]) mst[b] = M_BUSY;
          M_BUSY: begin
            if (eset[b]) mst[b] = M_ERR;
            else if (dset[b]) begin
              mst[b] = M_DONE;
              c++;
            end
          end
          M_DONE: begin
            if (start[b]) mst[b] = M_BUSY;
            else if (clr[b] || cyc[ch]) mst[b] = M_IDLE;
          end
          default: if (clr[b]) mst[b] = M_IDLE;
        endcase
        if (mst[b] == M_ERR) anyerr = 1'b1;
      end
      mcnt[ch]  = (mcnt[ch] + c) % 256;
      mcoal[ch] = ack[ch] ? c : mcoal[ch] + c;
      if (mcoal[ch] > 15) mcoal[ch] = 15;
      th = int'(thresh[ch*4 +: 4]);
      if (th == 0) th = 1;
      mirq[ch] = en[ch] && (mcoal[ch] >= th || anyerr);
    end
  endfunction

  task automatic check_all(input string tag);
    logic [15:0] eb, ed, ee;
    logic [31:0] ec;
    logic [3:0]  ei;
    for (int i = 0; i < 16; i++) begin
      eb[i] = (mst[i] == M_BUSY);
      ed[i] = (mst[i] == M_DONE);
      ee[i] = (mst[i] == M_ERR);
    end
    for (int ch = 0; ch < 4; ch++) begin
      ec[ch*8 +: 8] = 8'(mcnt[ch]);
      ei[ch]        = mirq[ch];
    end
    chk({tag, " busy"}, xfer_busy, eb);
    chk({tag, " done"}, xfer_done, ed);
    chk({tag, " err"}, xfer_err, ee);
    chk({tag, " cnt"}, chn_xfer_cnt, ec);
    chk({tag, " irq"}, chn_irq, ei);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    start = '0;
    dset  = '0;
    eset  = '0;
    clr   = '0;
    ack   = '0;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = '0;
    dset   = '0;
    eset   = '0;
    clr    = '0;
    cyc    = '0;
    ack    = '0;
    en     = 4'hF;
    thresh = 16'h1111;
    tmo    = '0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset_busy0", xfer_busy, 16'h0);
    chk("reset_irq0", chn_irq, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // single descriptor lifecycle on ch0 desc1
    start[1] = 1'b1;
    tick("t1_start");
    chk("t1_busy", xfer_busy[1], 1'b1);
    for (int i = 0; i < 4; i++) tick("t1_wait");
    dset[1] = 1'b1;
    tick("t1_done");
    chk("t1_done", xfer_done[1], 1'b1);
    chk("t1_cnt", chn_xfer_cnt[7:0], 8'd1);
    chk("t1_irq", chn_irq[0], 1'b1);
    clr[1] = 1'b1;
    ack[0] = 1'b1;
    tick("t1_clr");
    chk("t1_idle", xfer_done[1], 1'b0);
    chk("t1_irq_ack", chn_irq[0], 1'b0);

    // cyclic coalescing on ch1 desc4, threshold 3
    cyc[1] = 1'b1;
    thresh[7:4] = 4'd3;
    start[4] = 1'b1;
    tick("t2_start");
    for (int k = 1; k <= 3; k++) begin
      dset[4] = 1'b1;
      tick("t2_done");
      chk("t2_pulse", xfer_done[4], 1'b1);
      chk("t2_irq", chn_irq[1], 1'(k == 3));
      start[4] = 1'b1;
      tick("t2_restart");
      chk("t2_pulse_end", xfer_done[4], 1'b0);
    end
    dset[4] = 1'b1;
    ack[1]  = 1'b1;
    tick("t2_ack4");
    chk("t2_ack_irq", chn_irq[1], 1'b0);
    for (int k = 1; k <= 2; k++) begin
      start[4] = 1'b1;
      tick("t2_restart2");
      dset[4] = 1'b1;
      tick("t2_done2");
      chk("t2_coal_kept", chn_irq[1], 1'(k == 2));
    end
    ack[1] = 1'b1;
    tick("t2_clr_irq");

    // simultaneous done/err on ch2
    start[8]  = 1'b1;
    start[10] = 1'b1;
    tick("t3_start");
    dset[8]  = 1'b1;
    dset[10] = 1'b1;
    eset[10] = 1'b1;
    tick("t3_evt");
    chk("t3_done8", xfer_done[8], 1'b1);
    chk("t3_err10", xfer_err[10], 1'b1);
    chk("t3_cnt", chn_xfer_cnt[23:16], 8'd1);
    chk("t3_irq", chn_irq[2], 1'b1);
    ack[2] = 1'b1;
    tick("t3_ack");
    chk("t3_irq_err", chn_irq[2], 1'b1);
    clr[10] = 1'b1;
    tick("t3_clr");
    chk("t3_irq_drop", chn_irq[2], 1'b0);

    // counter wrap and coalesce saturation on ch3
    thresh[15:12] = 4'hF;
    for (int i = 0; i < 64; i++) begin
      start = 16'hF000;
      tick("t4_start");
      dset = 16'hF000;
      tick("t4_done");
      if (i == 31) chk("t4_half", chn_xfer_cnt[31:24], 8'd128);
    end
    chk("t4_wrap", chn_xfer_cnt[31:24], 8'd0);
    chk("t4_sat_irq", chn_irq[3], 1'b1);
    ack[3] = 1'b1;
    tick("t4_ack");
    chk("t4_ack_irq", chn_irq[3], 1'b0);

    // asynchronous reset mid-operation
    start[0] = 1'b1;
    start[1] = 1'b1;
    tick("t5_start");
    dset[1] = 1'b1;
    tick("t5_done");
    chk("t5_irq_pre", chn_irq[0], 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t5_rst");
    chk("t5_rst_cnt", chn_xfer_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dset[0] = 1'b1;
    tick("t5_post");
    chk("t5_ignored", xfer_done[0], 1'b0);

`ifdef ADMA_XFER_STAT_TIMEOUT_EN
    begin
      bit found;
      found = 1'b0;
      tmo[63:48] = 16'd10;
      start[12] = 1'b1;
      @(posedge clk);
      #1;
      start[12] = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        @(posedge clk);
        #1;
        if (xfer_err[12]) found = 1'b1;
      end
      chk("wd_err", xfer_err[12], 1'b1);
      chk("wd_irq", chn_irq[3], 1'b1);
      tmo = '0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
      start[12] = 1'b1;
      tick("wd_off_start");
      for (int i = 0; i < 30; i++) tick("wd_off");
      chk("wd_off_busy", xfer_busy[12], 1'b1);
    end
`endif

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      start = 16'($urandom) & 16'($urandom);
      dset  = 16'($urandom) & 16'($urandom);
      eset  = 16'($urandom) & 16'($urandom) & 16'($urandom);
      clr   = 16'($urandom) & 16'($urandom);
      ack   = 4'($urandom) & 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 15) == 0) cyc = 4'($urandom);
      if ($urandom_range(0, 31) == 0) en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) thresh = 16'($urandom);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
